dma_prog_if: RTL

//  CPU programming interface of the 8237A-style DMA controller. Decodes slave-mode CPU I/O cycles
//  (CS_N/IOR_N/IOW_N/A[3:0]/DB) into the channel, command, mode, mask, request and status registers.

---
 rtl/dma_reg_pkg.sv | 44 ++++
 rtl/dma_bus_strobe.sv | 39 +++
 rtl/dma_prog_if.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dma_reg_pkg.sv
// Register layouts and CPU register-address map for the 8237A-style programming interface.
package dma_reg_pkg;

    typedef struct packed {
        logic dack_hi;
        logic dreq_lo;
        logic ext_wr;
        logic rot_pri;
        logic cmp_tim;
        logic ctl_dis;
        logic ch0_hold;
        logic mem2mem;
    } cmd_reg_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       dec;
        logic       autoinit;
        logic [1:0] xfer;
        logic [1:0] sel;
    } mode_reg_t;

    typedef logic [3:0] mask_reg_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] tc;
    } status_reg_t;

    localparam logic [3:0] REG_CMD     = 4'h8;
    localparam logic [3:0] REG_STATUS  = 4'h8;
    localparam logic [3:0] REG_REQ     = 4'h9;
    localparam logic [3:0] REG_MASK1   = 4'hA;
    localparam logic [3:0] REG_MODE    = 4'hB;
    localparam logic [3:0] REG_CLRBP   = 4'hC;
    localparam logic [3:0] REG_MCLR    = 4'hD;
    localparam logic [3:0] REG_TEMP    = 4'hD;
    localparam logic [3:0] REG_CLRMASK = 4'hE;
    localparam logic [3:0] REG_WRMASK  = 4'hF;

    // Stored mode field is mode_reg_t[7:2]; auto-init lands at bit 2 of it.
    localparam int MODE_AUTOINIT_BIT = 2;

endpackage

// File: rtl/dma_bus_strobe.sv
// Samples the CPU strobes and produces one-cycle write-commit / read-end pulses on strobe release.
module dma_bus_strobe
    import dma_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       ior_n,
    input  logic       iow_n,
    input  logic [3:0] a,
    input  logic [7:0] db,
    output logic       wr_commit,
    output logic       rd_end,
    output logic [3:0] a_q,
    output logic [7:0] db_q
);
    logic cs_q, ior_q, iow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= 1'b1;
            ior_q <= 1'b1;
            iow_q <= 1'b1;
            a_q   <= '0;
            db_q  <= '0;
        end else begin
            cs_q  <= cs_n;
            ior_q <= ior_n;
            iow_q <= iow_n;
            if (!cs_n && (!ior_n || !iow_n)) a_q <= a;
            if (!cs_n && !iow_n) db_q <= db;
        end
    end

    // A write overlapped by a read strobe is a bus conflict and never commits.
    assign wr_commit = iow_n && !iow_q && !cs_q && ior_q;
    assign rd_end    = ior_n && !ior_q && !cs_q;

endmodule

// File: rtl/dma_prog_if.sv
// CPU programming interface of the DMA controller: register file, byte pointer and TC handling.
// Optional DMA_AUTOINIT_EN: honour mode auto-init (reload current from base on TC, keep mask).
module dma_prog_if
    import dma_reg_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     CS_N,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic [3:0]               A,
    input  logic [7:0]               DB_IN,
    output logic [7:0]               DB_OUT,
    output logic                     DB_OE,
    input  logic [NUM_CH-1:0]        dreq_i,
    input  logic                     upd_en,
    input  logic [1:0]               upd_ch,
    input  logic [ADDR_W-1:0]        upd_addr,
    input  logic [ADDR_W-1:0]        upd_count,
    input  logic [NUM_CH-1:0]        tc_i,
    output logic [7:0]               cmd_o,
    output logic [6*NUM_CH-1:0]      mode_o,
    output logic [NUM_CH-1:0]        mask_o,
    output logic [NUM_CH-1:0]        sreq_o,
    output logic [ADDR_W*NUM_CH-1:0] cur_addr_o,
    output logic [ADDR_W*NUM_CH-1:0] cur_count_o,
    output logic                     mclr_o
);
    logic       wr_commit, rd_end;
    logic [3:0] a_q;
    logic [7:0] db_q;

    dma_bus_strobe u_strobe (
        .clk(CLK), .rst_n(RESET_N), .cs_n(CS_N), .ior_n(IOR_N), .iow_n(IOW_N),
        .a(A), .db(DB_IN), .wr_commit(wr_commit), .rd_end(rd_end), .a_q(a_q), .db_q(db_q)
    );

    cmd_reg_t                       cmd, n_cmd;
    logic [NUM_CH-1:0][5:0]         mode, n_mode;
    mask_reg_t                      mask, n_mask;
    logic [NUM_CH-1:0]              sreq, n_sreq, tc_st, n_tc;
    logic                           bp, n_bp;
    logic [NUM_CH-1:0][ADDR_W-1:0]  base_addr, n_base_addr, base_cnt, n_base_cnt;
    logic [NUM_CH-1:0][ADDR_W-1:0]  cur_addr, n_cur_addr, cur_cnt, n_cur_cnt;
    logic                           chan_wr;
    logic [1:0]                     wr_ch;

    assign chan_wr = wr_commit && !a_q[3];
    assign wr_ch   = a_q[2:1];

    always_comb begin
        n_cmd = cmd; n_mode = mode; n_mask = mask; n_sreq = sreq; n_tc = tc_st; n_bp = bp;
        n_base_addr = base_addr; n_base_cnt = base_cnt; n_cur_addr = cur_addr; n_cur_cnt = cur_cnt;

        if (rd_end && a_q == REG_STATUS) n_tc = '0;
        if (rd_end && !a_q[3])           n_bp = ~bp;

        // Priority per channel: FSM write-back < TC reload < CPU write.
        for (int n = 0; n < NUM_CH; n++) begin
            if (upd_en && upd_ch == 2'(n)) begin
                if (!(chan_wr && wr_ch == 2'(n) && !a_q[0])) n_cur_addr[n] = upd_addr;
                if (!(chan_wr && wr_ch == 2'(n) &&  a_q[0])) n_cur_cnt[n]  = upd_count;
            end
            if (tc_i[n]) begin
                n_tc[n]   = 1'b1;
                n_sreq[n] = 1'b0;
`ifdef DMA_AUTOINIT_EN
                if (mode[n][MODE_AUTOINIT_BIT]) begin
                    n_cur_addr[n] = base_addr[n];
                    n_cur_cnt[n]  = base_cnt[n];
                end else begin
                    n_mask[n] = 1'b1;
                end
`else
                n_mask[n] = 1'b1;
`endif
            end
        end

        if (chan_wr) begin
            n_bp = ~bp;
            if (a_q[0]) begin
                if (bp) begin
                    n_base_cnt[wr_ch][15:8] = db_q; n_cur_cnt[wr_ch][15:8] = db_q;
                end else begin
                    n_base_cnt[wr_ch][7:0]  = db_q; n_cur_cnt[wr_ch][7:0]  = db_q;
                end
            end else begin
                if (bp) begin
                    n_base_addr[wr_ch][15:8] = db_q; n_cur_addr[wr_ch][15:8] = db_q;
                end else begin
                    n_base_addr[wr_ch][7:0]  = db_q; n_cur_addr[wr_ch][7:0]  = db_q;
                end
            end
        end else if (wr_commit) begin
            case (a_q)
                REG_CMD:     n_cmd = cmd_reg_t'(db_q);
                REG_REQ:     n_sreq[db_q[1:0]] = db_q[2];
                REG_MASK1:   n_mask[db_q[1:0]] = db_q[2];
                REG_MODE:    n_mode[db_q[1:0]] = db_q[7:2];
                REG_CLRBP:   n_bp = 1'b0;
                REG_CLRMASK: n_mask = '0;
                REG_WRMASK:  n_mask = db_q[3:0];
                default: ;
            endcase
        end

        if (wr_commit && a_q == REG_MCLR) begin
            n_cmd = '0; n_mode = '0; n_mask = '1; n_sreq = '0; n_tc = '0; n_bp = 1'b0;
            n_base_addr = '0; n_base_cnt = '0; n_cur_addr = '0; n_cur_cnt = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd <= '0; mode <= '0; mask <= '1; sreq <= '0; tc_st <= '0; bp <= 1'b0;
            base_addr <= '0; base_cnt <= '0; cur_addr <= '0; cur_cnt <= '0;
            mclr_o <= 1'b0;
        end else begin
            cmd <= n_cmd; mode <= n_mode; mask <= n_mask; sreq <= n_sreq; tc_st <= n_tc; bp <= n_bp;
            base_addr <= n_base_addr; base_cnt <= n_base_cnt;
            cur_addr <= n_cur_addr; cur_cnt <= n_cur_cnt;
            mclr_o <= wr_commit && a_q == REG_MCLR;
        end
    end

    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] rd_sel;
    status_reg_t       st;

    always_comb begin
        st.req  = dreq_i;
        st.tc   = tc_st;
        rd_sel  = A[0] ? cur_cnt[A[2:1]] : cur_addr[A[2:1]];
        rd_data = 8'h00;
        if (!A[3])                rd_data = bp ? rd_sel[15:8] : rd_sel[7:0];
        else if (A == REG_STATUS) rd_data = st;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)             DB_OUT <= 8'h00;
        else if (!CS_N && !IOR_N) DB_OUT <= rd_data;
    end

    assign DB_OE       = !CS_N && !IOR_N;
    assign cmd_o       = cmd;
    assign mode_o      = mode;
    assign mask_o      = mask;
    assign sreq_o      = sreq;
    assign cur_addr_o  = cur_addr;
    assign cur_count_o = cur_cnt;

endmodule
